// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle main-control sequencer.
//   state_t      FSM state encoding
//   ALU_B_*      encodings of the ALU B-operand select (alu_src_b)
//   PC_SRC_*     encodings of the PC source select (pc_src)
//   dec_t        decoder fields captured in DECODE for use in later states
//   is_mem_state true for states that hold a memory request open
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_JUMP,
    S_ERR
  } state_t;

  localparam logic [1:0] ALU_B_RT     = 2'b00;
  localparam logic [1:0] ALU_B_FOUR   = 2'b01;
  localparam logic [1:0] ALU_B_IMM    = 2'b10;
  localparam logic [1:0] ALU_B_IMMSL2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic mem_to_reg;
    logic alu_src;
    logic reg_write;
  } dec_t;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts consecutive stalled cycles of a memory request and
// flags a timeout.
//   clk      in  clock
//   rst_n    in  synchronous active-low reset
//   en       in  current cycle is a stalled memory cycle (request open, ready low)
//   clr      in  restart the count (the FSM is changing state)
//   expired  out this stalled cycle is the MAX-th in a row; always 0 when MAX = 0
module mc_wait_timer #(
  parameter int unsigned MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int unsigned W = (MAX < 2) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] cnt_q;
  logic [W:0]   cnt_inc;

  // cnt_q holds the stalls already seen, so cnt_inc counts the current cycle too.
  assign cnt_inc = {1'b0, cnt_q} + (W + 1)'(1);

  // A stalled cycle with ready low raises expired; a cycle with ready high never
  // has en set, so a completion on the boundary cycle always wins.
  assign expired = (MAX != 0) && en && (cnt_inc >= (W + 1)'(MAX));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt_q <= '0;
    end else if (en && !(&cnt_q)) begin
      // Saturate so an unbounded stall (MAX = 0) cannot wrap back to zero.
      cnt_q <= cnt_inc[W-1:0];
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle main-control FSM for the MIPS datapath. Turns the
// combinational decoder's per-instruction signals into per-cycle strobes and
// handshakes with memory through mem_req/mem_ready, trapping a stalled bus.
//
// Optional feature: define MC_PERF_CNT_EN to build the cycle and retired-
// instruction counters; otherwise cyc_cnt/instr_cnt are tied to 0.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   mem_to_reg, mem_write,     decoder outputs, sampled in DECODE
//   branch, jump, alu_src,
//   reg_write
//   mem_ready                  memory completes the open request this cycle
//   mem_req, mem_we, i_or_d    memory request, write flag, address select
//   ir_write, pc_write,        datapath register strobes
//   pc_write_cond, reg_write_en
//   alu_src_a, alu_src_b,      datapath mux selects
//   pc_src
//   instr_done                 pulse in the last cycle of an instruction
//   bus_err                    high while trapped in ERR
//   cyc_cnt, instr_cnt         performance counters
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_to_reg,
  input  logic             mem_write,
  input  logic             branch,
  input  logic             jump,
  input  logic             alu_src,
  input  logic             reg_write,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             reg_write_en,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic             instr_done,
  output logic             bus_err,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t state_q, state_d;
  dec_t   dec_q;
  logic   wait_en;
  logic   expired;

  assign wait_en = is_mem_state(state_q) && !mem_ready;

  mc_wait_timer #(.MAX(MEM_WAIT_MAX)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (wait_en),
    .clr     (state_d != state_q),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: dec_q is a plain data register with no reset; it is only read in
  // states that are reached through DECODE, which always loads it first.
  always_ff @(posedge clk) begin
    if (state_q == S_DECODE) dec_q <= '{mem_to_reg: mem_to_reg, alu_src: alu_src, reg_write: reg_write};
  end

  always_comb begin
    // NOTE: every output and state_d gets a default before the case so no path
    // leaves a variable unassigned (which would infer a latch).
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write_en  = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALU_B_RT;
    pc_src        = PC_SRC_ALU;
    instr_done    = 1'b0;
    bus_err       = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = ALU_B_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (expired) begin
          state_d = S_ERR;
        end
      end
      S_DECODE: begin
        alu_src_b = ALU_B_IMMSL2;
        if (jump)                        state_d = S_JUMP;
        else if (branch)                 state_d = S_BRANCH;
        else if (mem_to_reg | mem_write) state_d = S_MEMADR;
        else                             state_d = S_EXEC;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
        state_d   = dec_q.mem_to_reg ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready)    state_d = S_MEMWB;
        else if (expired) state_d = S_ERR;
      end
      S_MEMWB: begin
        reg_write_en = 1'b1;
        instr_done   = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (expired) begin
          state_d = S_ERR;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = dec_q.alu_src ? ALU_B_IMM : ALU_B_RT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_en = dec_q.reg_write;
        instr_done   = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = ALU_B_RT;
        pc_src        = PC_SRC_ALUOUT;
        pc_write_cond = 1'b1;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = PC_SRC_JUMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: begin
        // ERR, and any unused encoding, traps until reset.
        bus_err = 1'b1;
        state_d = S_ERR;
      end
    endcase
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, instr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q   <= '0;
      instr_q <= '0;
    end else begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (instr_done) instr_q <= instr_q + CNT_W'(1);
    end
  end

  assign cyc_cnt   = cyc_q;
  assign instr_cnt = instr_q;
`else
  assign cyc_cnt   = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: directed bench for mc_sequencer built with MEM_WAIT_MAX = 4.
// Outputs are packed into one vector and compared against hand-written
// per-state patterns; counters are compared against 0 unless MC_PERF_CNT_EN.
module tb_mc_sequencer;

  localparam int CNT_W = 32;
`ifdef MC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic mem_to_reg, mem_write, branch, jump, alu_src, reg_write, mem_ready;
  logic mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, reg_write_en;
  logic alu_src_a, instr_done, bus_err;
  logic [1:0] alu_src_b, pc_src;
  logic [CNT_W-1:0] cyc_cnt, instr_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_exp  = 0;
  int req_cycles;

  always #5 clk = ~clk;

  mc_sequencer #(.MEM_WAIT_MAX(4), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_to_reg    (mem_to_reg),
    .mem_write     (mem_write),
    .branch        (branch),
    .jump          (jump),
    .alu_src       (alu_src),
    .reg_write     (reg_write),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .i_or_d        (i_or_d),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .reg_write_en  (reg_write_en),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_src        (pc_src),
    .instr_done    (instr_done),
    .bus_err       (bus_err),
    .cyc_cnt       (cyc_cnt),
    .instr_cnt     (instr_cnt)
  );

  logic [13:0] obs;
  assign obs = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, reg_write_en,
                alu_src_a, alu_src_b, pc_src, instr_done, bus_err};

  function automatic logic [13:0] ev(input logic req, we, iod, irw, pcw, pcwc, rwe, sa,
                                     input logic [1:0] sb, ps, input logic done, err);
    return {req, we, iod, irw, pcw, pcwc, rwe, sa, sb, ps, done, err};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge and outputs are
  // sampled after a further settle delay.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) cyc_exp = 0;
    else        cyc_exp++;
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [13:0] e_idle, e_fetch_w, e_fetch_r, e_dec, e_exec_r, e_aluwb, e_memadr, e_memrd;
  logic [13:0] e_memwb, e_memwr_w, e_memwr_r, e_branch, e_jump, e_err;

  initial begin
    e_idle     = '0;
    e_fetch_w  = ev(1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
    e_fetch_r  = ev(1, 0, 0, 1, 1, 0, 0, 0, 2'b01, 2'b00, 0, 0);
    e_dec      = ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0);
    e_exec_r   = ev(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    e_aluwb    = ev(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0);
    e_memadr   = ev(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0);
    e_memrd    = ev(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    e_memwb    = ev(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0);
    e_memwr_w  = ev(1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    e_memwr_r  = ev(1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
    e_branch   = ev(0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b01, 1, 0);
    e_jump     = ev(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b10, 1, 0);
    e_err      = ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1);

    rst_n = 1'b0;
    {mem_to_reg, mem_write, branch, jump, alu_src, reg_write, mem_ready} = '0;

    // 1. Reset, then an R-type with zero-wait memory: done in cycle 5.
    tick(); tick(); settle();
    check("rst_idle", obs, e_idle);
    check("rst_cyc_cnt", cyc_cnt, 0);
    check("rst_instr_cnt", instr_cnt, 0);
    rst_n = 1'b1; mem_ready = 1'b1; reg_write = 1'b1; settle();
    check("idle_ignores_ready", obs, e_idle);
    tick(); settle(); check("t1_fetch", obs, e_fetch_r);
    tick(); settle(); check("t1_decode", obs, e_dec);
    tick(); settle(); check("t1_exec_srcb_rt", obs, e_exec_r);
    tick(); settle(); check("t1_aluwb_done_c5", obs, e_aluwb);
    check("t1_cyc_cnt", cyc_cnt, PERF ? cyc_exp : 0);

    // 2. Load with three stalled cycles in MEMRD.
    mem_to_reg = 1'b1; alu_src = 1'b1;
    tick(); settle(); check("t2_fetch", obs, e_fetch_r);
    check("t2_instr_cnt_1", instr_cnt, PERF ? 1 : 0);
    tick(); settle(); check("t2_decode", obs, e_dec);
    mem_ready = 1'b0;
    tick(); settle(); check("t2_memadr", obs, e_memadr);
    req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) mem_ready = 1'b1;
      settle();
      check("t2_memrd", obs, e_memrd);
      if (mem_req) req_cycles++;
    end
    check("t2_req_held_4", req_cycles, 4);
    tick(); settle(); check("t2_memwb_rwe", obs, e_memwb);
    mem_to_reg = 1'b0; mem_write = 1'b1; alu_src = 1'b1; reg_write = 1'b0;
    tick(); settle(); check("t2_instr_cnt_2", instr_cnt, PERF ? 2 : 0);

    // 3. Store, then a branch right behind it.
    check("t3_fetch", obs, e_fetch_r);
    tick(); settle(); check("t3_decode", obs, e_dec);
    mem_ready = 1'b0;
    tick(); settle(); check("t3_memadr", obs, e_memadr);
    tick(); settle(); check("t3_memwr_wait", obs, e_memwr_w);
    mem_ready = 1'b1; settle();
    check("t3_memwr_done", obs, e_memwr_r);
    mem_write = 1'b0; branch = 1'b1;
    tick(); settle(); check("t3_fetch_no_we", obs, e_fetch_r);
    tick(); settle(); check("t3_decode_br", obs, e_dec);
    tick(); settle(); check("t3_branch", obs, e_branch);

    // 4. Jump and branch both set: jump takes priority.
    jump = 1'b1;
    tick(); settle(); check("t4_fetch", obs, e_fetch_r);
    tick(); settle(); check("t4_decode", obs, e_dec);
    tick(); settle(); check("t4_jump", obs, e_jump);
    mem_ready = 1'b0; jump = 1'b0; branch = 1'b0;
    tick(); settle(); check("t4_pcw_one_cycle", obs, e_fetch_w);

    // 5. Stuck FETCH: four stalled cycles, then ERR until reset.
    for (int i = 0; i < 3; i++) begin
      tick(); settle(); check("t5_fetch_wait", obs, e_fetch_w);
    end
    tick(); settle(); check("t5_err", obs, e_err);
    mem_ready = 1'b1;
    tick(); settle(); check("t5_err_sticky", obs, e_err);
    check("t5_instr_cnt_5", instr_cnt, PERF ? 5 : 0);
    rst_n = 1'b0;
    tick(); settle(); check("t5_rst_idle", obs, e_idle);
    rst_n = 1'b1;

    // 6. Reset while a store is stalled.
    mem_write = 1'b1;
    tick(); settle(); check("t6_fetch", obs, e_fetch_r);
    tick(); tick(); mem_ready = 1'b0;
    tick(); settle(); check("t6_memwr_wait", obs, e_memwr_w);
    rst_n = 1'b0;
    tick(); settle(); check("t6_rst_idle", obs, e_idle);
    check("t6_cyc_cnt", cyc_cnt, 0);
    check("t6_instr_cnt", instr_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
